// File: rtl/dual_channel_decimator_if.sv
// rtl/dual_channel_decimator_if.sv - Register bus plus input and output sample streams for dual_channel_decimator
//
// Purpose: bundles the Avalon-MM style register slave and the two sample
// streams so the decimator and its driver share one connection.
// Ports (signals):
//   avs_s0_address/read/readdata/write/writedata  4-word register slave
//   asi_in0_data/valid                            {ch1, ch0} input samples, no backpressure
//   aso_out0_data/valid                           {ch1, ch0} reduced samples
// Modports: master drives requests and samples, slave is the decimator.
interface dual_channel_decimator_if #(
    parameter int DATA_W = 16
);
    logic [1:0]          avs_s0_address;
    logic                avs_s0_read;
    logic [31:0]         avs_s0_readdata;
    logic                avs_s0_write;
    logic [31:0]         avs_s0_writedata;
    logic [2*DATA_W-1:0] asi_in0_data;
    logic                asi_in0_valid;
    logic [2*DATA_W-1:0] aso_out0_data;
    logic                aso_out0_valid;

    modport master (
        output avs_s0_address, avs_s0_read, avs_s0_write, avs_s0_writedata,
        output asi_in0_data, asi_in0_valid,
        input  avs_s0_readdata, aso_out0_data, aso_out0_valid
    );

    modport slave (
        input  avs_s0_address, avs_s0_read, avs_s0_write, avs_s0_writedata,
        input  asi_in0_data, asi_in0_valid,
        output avs_s0_readdata, aso_out0_data, aso_out0_valid
    );
endinterface

// File: rtl/dual_channel_decimator.sv
// rtl/dual_channel_decimator.sv - Dual-channel boxcar-average / peak-hold decimator with register slave
//
// Purpose: reduces each block of 2^LOG2N packed {ch1, ch0} samples to one
// output word, either by per-channel average (floor) or per-channel max.
// Ports:
//   csi_clk    single rising-edge clock
//   rsi_reset  synchronous active-high reset
//   io         register slave, input stream and output stream (slave modport)
// Registers: 0 CTRL {mode[2:1], enable[0]}, 1 LOG2N[3:0] (clamped),
//            2 COUNT (write clears), 3 LAST output word.
module dual_channel_decimator #(
    parameter int DATA_W   = 16,
    parameter int MAX_LOG2 = 8
) (
    input  logic                     csi_clk,
    input  logic                     rsi_reset,
    dual_channel_decimator_if.slave  io
);
    localparam int ACC_W = DATA_W + MAX_LOG2;
    localparam logic [3:0] LOG2_LIMIT = 4'(MAX_LOG2);
    localparam logic [MAX_LOG2:0] ONE = 1;

    logic                enable;
    logic [1:0]          mode;
    logic [3:0]          log2n;
    logic [31:0]         out_count;
    logic [ACC_W-1:0]    acc0;
    logic [ACC_W-1:0]    acc1;
    logic [MAX_LOG2-1:0] sample_cnt;
    logic [2*DATA_W-1:0] out_data;
    logic                out_valid;

    logic [DATA_W-1:0]   in0;
    logic [DATA_W-1:0]   in1;
    logic                accept;
    logic                cfg_write;
    logic                count_clear;
    logic                is_pass;
    logic                is_peak;
    logic [MAX_LOG2:0]   block_last_idx;
    logic                last_sample;
    logic [ACC_W-1:0]    sum0;
    logic [ACC_W-1:0]    sum1;
    logic [ACC_W-1:0]    peak0;
    logic [ACC_W-1:0]    peak1;
    logic [ACC_W-1:0]    avg0;
    logic [ACC_W-1:0]    avg1;
    logic [DATA_W-1:0]   red0;
    logic [DATA_W-1:0]   red1;
    logic [31:0]         read_mux;
    logic [27:0]         unused_wdata;

    assign in0 = io.asi_in0_data[DATA_W-1:0];
    assign in1 = io.asi_in0_data[2*DATA_W-1:DATA_W];

    // A register write in the same cycle as a sample always wins; the sample is lost.
    assign accept      = enable && io.asi_in0_valid && !io.avs_s0_write;
    assign cfg_write   = io.avs_s0_write && (io.avs_s0_address == 2'd0 || io.avs_s0_address == 2'd1);
    assign count_clear = io.avs_s0_write && (io.avs_s0_address == 2'd2);

    // Modes 0 and 3 pass through, as does any mode with a block length of one.
    assign is_pass = (mode == 2'd0) || (mode == 2'd3) || (log2n == 4'd0);
    assign is_peak = (mode == 2'd2);

    assign block_last_idx = (ONE << log2n) - ONE;
    assign last_sample    = ({1'b0, sample_cnt} == block_last_idx);

    // The accumulator never holds the current sample, so the block result
    // is always formed from accumulator plus the sample arriving now.
    assign sum0  = acc0 + ACC_W'(in0);
    assign sum1  = acc1 + ACC_W'(in1);
    assign peak0 = (ACC_W'(in0) > acc0) ? ACC_W'(in0) : acc0;
    assign peak1 = (ACC_W'(in1) > acc1) ? ACC_W'(in1) : acc1;
    assign avg0  = sum0 >> log2n;
    assign avg1  = sum1 >> log2n;
    assign red0  = is_peak ? peak0[DATA_W-1:0] : avg0[DATA_W-1:0];
    assign red1  = is_peak ? peak1[DATA_W-1:0] : avg1[DATA_W-1:0];

    always_ff @(posedge csi_clk) begin
        if (rsi_reset) begin
            enable     <= 1'b0;
            mode       <= 2'd0;
            log2n      <= 4'd0;
            out_count  <= 32'd0;
            acc0       <= '0;
            acc1       <= '0;
            sample_cnt <= '0;
            out_data   <= '0;
            out_valid  <= 1'b0;
        end else begin
            out_valid <= 1'b0;

            if (io.avs_s0_write) begin
                case (io.avs_s0_address)
                    2'd0: begin
                        enable <= io.avs_s0_writedata[0];
                        mode   <= io.avs_s0_writedata[2:1];
                    end
                    2'd1: log2n <= (io.avs_s0_writedata[3:0] > LOG2_LIMIT) ? LOG2_LIMIT
                                                                          : io.avs_s0_writedata[3:0];
                    default: ;
                endcase
            end

            if (count_clear) begin
                out_count <= 32'd0;
            end else if (accept && (is_pass || last_sample)) begin
                out_count <= out_count + 32'd1;
            end

            if (!enable || cfg_write) begin
                acc0       <= '0;
                acc1       <= '0;
                sample_cnt <= '0;
            end else if (accept) begin
                if (is_pass) begin
                    out_data  <= io.asi_in0_data;
                    out_valid <= 1'b1;
                end else if (last_sample) begin
                    out_data   <= {red1, red0};
                    out_valid  <= 1'b1;
                    acc0       <= '0;
                    acc1       <= '0;
                    sample_cnt <= '0;
                end else begin
                    acc0       <= is_peak ? peak0 : sum0;
                    acc1       <= is_peak ? peak1 : sum1;
                    sample_cnt <= sample_cnt + 1'b1;
                end
            end
        end
    end

    always_comb begin
        read_mux = 32'd0;
        case (io.avs_s0_address)
            2'd0:    read_mux = {29'd0, mode, enable};
            2'd1:    read_mux = {28'd0, log2n};
            2'd2:    read_mux = out_count;
            default: read_mux = 32'(out_data);
        endcase
    end

    assign io.avs_s0_readdata = io.avs_s0_read ? read_mux : 32'd0;
    assign io.aso_out0_data   = out_data;
    assign io.aso_out0_valid  = out_valid;
    assign unused_wdata       = io.avs_s0_writedata[31:4];
endmodule
